debug_tx_sender: RTL and testbench
==================================

// Module: debug_tx_sender
// PURPOSE
//  Return path of the debug link: buffers 32-bit words pushed by the debug unit (register dump, latches,
//  mem data/addr pairs, "endd" marker) in a synchronous FIFO and serialises each word into 4 bytes for
//  the UART transmitter via a start/done byte handshake. Sits between debug_unit FIFO outputs and uart_tx.
// PARAMETERS
//  NB_DATA          32  word width; fixed at 32 (4 bytes/word)
//  FIFO_ADDR_WIDTH  6   FIFO depth = 2**FIFO_ADDR_WIDTH words (64)
// PORTS
//  i_clk            in   1        system clock, all logic on rising edge
//  i_reset          in   1        synchronous, active-high reset
//  i_write_en_fifo  in   1        push i_data_to_fifo this cycle (one word per high cycle)
//  i_data_to_fifo   in   NB_DATA  word to buffer
//  o_fifo_full      out  1        FIFO holds 2**FIFO_ADDR_WIDTH words
//  o_fifo_empty     out  1        FIFO holds 0 words
//  o_overflow       out  1        sticky: a push was dropped because FIFO was full
//  o_busy           out  1        FSM not in IDLE or FIFO not empty
//  o_tx_start       out  1        one-cycle pulse: uart_tx must send o_tx_data
//  o_tx_data        out  8        byte to transmit, valid when o_tx_start=1, held until next start
//  i_tx_done        in   1        one-cycle pulse from uart_tx: byte fully shifted out
// BEHAVIOUR
//  Reset: wr/rd pointers=0, count=0, FSM=IDLE, byte index=0; o_tx_start=0, o_tx_data=8'h00,
//   o_fifo_empty=1, o_fifo_full=0, o_overflow=0, o_busy=0. Reset mid-word discards FIFO + in-flight word.
//  FIFO: count is FIFO_ADDR_WIDTH+1 bits; full/empty are registered flags decoded from count.
//   Push accepted when i_write_en_fifo=1 and o_fifo_full=0 (value at that edge); write at wr_ptr, wr_ptr+1.
//   Push while full: word dropped, o_overflow<=1 until reset; pointers/count unchanged by the push.
//   Pop only from FSM IDLE when o_fifo_empty=0. Push+pop same cycle: both done, count unchanged.
//   Pointers wrap modulo 2**FIFO_ADDR_WIDTH.
//  FSM states:
//   IDLE      : if !o_fifo_empty -> pop word into 32-bit shift reg, byte index<=0 -> SEND; else stay.
//   SEND      : o_tx_start<=1 for exactly one cycle, o_tx_data<=selected byte -> WAIT.
//   WAIT      : o_tx_start=0; on i_tx_done: if byte index==3 -> IDLE, else byte index+1 -> SEND.
//  i_tx_done outside WAIT is ignored. No timeout in WAIT; block stalls until uart_tx answers.
//  Latency: push at edge N -> o_fifo_empty=0 after N -> pop at N+1 -> o_tx_start high after N+2.
//   Per byte: i_tx_done at edge M -> next o_tx_start high after M+1 (SEND then pulse). Word-to-word gap: +1 (IDLE).
//  o_busy combinational: (state!=IDLE) | ~o_fifo_empty.
// CONFIGURATION
//  DEBUG_TX_MSB_FIRST_EN defined  : byte order [31:24],[23:16],[15:8],[7:0] (ASCII "endd" arrives e,n,d,d).
//  DEBUG_TX_MSB_FIRST_EN undefined: byte order [7:0],[15:8],[23:16],[31:24] (LSB first, default).
//  Only the byte-select mux changes; FSM, timing and FIFO identical in both builds.
// TESTING
//  1 reset, push 32'h656E6464 once, bench answers i_tx_done 3 cycles after each start -> o_tx_start 2 cycles
//    after push; bytes 64,64,6E,65 (default) / 65,6E,64,64 (macro); then o_busy=0, o_fifo_empty=1.
//  2 push 0..31 on 32 consecutive cycles, tx_done delayed 10 cycles -> o_fifo_full never 1, o_overflow=0,
//    128 bytes received in word order 0..31.
//  3 tx_done held low, push 70 consecutive words 100..169 -> words 100..164 accepted (1 in shift reg + 64 in
//    FIFO), o_fifo_full=1, 165..169 dropped, o_overflow=1; release tx_done -> exactly 65 words (260 bytes) out.
//  4 with FIFO at count 10, push and pop on same edge -> count stays 10, no data loss/duplication.
//  5 reset asserted after 2nd i_tx_done of a word -> next cycle o_tx_start=0, o_fifo_empty=1, o_overflow=0;
//    new push 32'hAABBCCDD transmits from byte 0 (DD first in default build).
//  6 i_tx_done pulses injected in IDLE and in SEND cycle -> ignored; byte index and byte stream unchanged.

Source files
------------

// File: rtl/debug_tx_sender.sv
// debug_tx_sender
//   Return path of the debug link. Buffers 32-bit words pushed by the debug
//   unit in a synchronous FIFO, then serialises every word into four bytes
//   for uart_tx using a start/done byte handshake.
//
//   Build option: define DEBUG_TX_MSB_FIRST_EN to send [31:24] first, so an
//   ASCII "endd" word arrives as e,n,d,d. When it is undefined, the block sends
//   [7:0] first. Only the byte-select mux differs between the two builds.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous, active-high reset
//   i_write_en_fifo  push i_data_to_fifo this cycle
//   i_data_to_fifo   word to buffer
//   o_fifo_full      FIFO holds 2**FIFO_ADDR_WIDTH words
//   o_fifo_empty     FIFO holds no words
//   o_overflow       sticky: a push was dropped because the FIFO was full
//   o_busy           a word is in flight or the FIFO is not empty
//   o_tx_start       one-cycle pulse: uart_tx must send o_tx_data
//   o_tx_data        byte to transmit, held until the next start
//   i_tx_done        one-cycle pulse from uart_tx: byte fully shifted out
module debug_tx_sender #(
    parameter int NB_DATA         = 32,
    parameter int FIFO_ADDR_WIDTH = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_write_en_fifo,
    input  logic [NB_DATA-1:0] i_data_to_fifo,
    output logic               o_fifo_full,
    output logic               o_fifo_empty,
    output logic               o_overflow,
    output logic               o_busy,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_done
);

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [NB_DATA-1:0]         mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic                       full_q, empty_q, overflow_q;
    logic                       push, pop;

    // Serialiser
    state_t                     state_q;
    logic [NB_DATA-1:0]         word_q;
    logic [1:0]                 byte_idx_q;
    logic                       tx_start_q;
    logic [7:0]                 tx_data_q;
    logic [7:0]                 byte_sel;

    // Pops happen only when the serialiser is idle; that same condition also
    // loads word_q in the FSM below.
    always_comb begin
        push = i_write_en_fifo & ~full_q;
        pop  = (state_q == IDLE) & ~empty_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data_to_fifo;
        end
    end

    // The full and empty flags are registered. They are decoded from the next
    // count, so they always match count_q.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
            if (i_write_en_fifo && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        byte_sel = '0;
`ifdef DEBUG_TX_MSB_FIRST_EN
        case (byte_idx_q)
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
`else
        case (byte_idx_q)
            2'd0:    byte_sel = word_q[7:0];
            2'd1:    byte_sel = word_q[15:8];
            2'd2:    byte_sel = word_q[23:16];
            default: byte_sel = word_q[31:24];
        endcase
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty_q) begin
                        word_q     <= mem_q[rd_ptr_q];
                        byte_idx_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= byte_sel;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (i_tx_done) begin
                        if (byte_idx_q == 2'd3) begin
                            state_q <= IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            state_q    <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_fifo_full  = full_q;
    assign o_fifo_empty = empty_q;
    assign o_overflow   = overflow_q;
    assign o_busy       = (state_q != IDLE) | ~empty_q;
    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;

endmodule

// File: tb/tb_debug_tx_sender.sv
// Testbench for debug_tx_sender. A uart_tx stand-in answers every start with
// a done pulse after a programmable delay. Each word the bench pushes and
// expects to be accepted adds its four bytes to an expected stream. The bench
// then compares that stream with the bytes the DUT actually started.
module tb_debug_tx_sender;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_write_en_fifo = 1'b0;
    logic [31:0] i_data_to_fifo = '0;
    logic        i_tx_done = 1'b0;
    logic        o_fifo_full, o_fifo_empty, o_overflow, o_busy, o_tx_start;
    logic [7:0]  o_tx_data;

    debug_tx_sender #(.NB_DATA(32), .FIFO_ADDR_WIDTH(6)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_write_en_fifo (i_write_en_fifo),
        .i_data_to_fifo  (i_data_to_fifo),
        .o_fifo_full     (o_fifo_full),
        .o_fifo_empty    (o_fifo_empty),
        .o_overflow      (o_overflow),
        .o_busy          (o_busy),
        .o_tx_start      (o_tx_start),
        .o_tx_data       (o_tx_data),
        .i_tx_done       (i_tx_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // uart_tx stand-in controls
    bit resp_en    = 1'b1;
    bit resp_rand  = 1'b0;
    bit resp_dbl   = 1'b0;
    int resp_delay = 3;
    bit saw_full   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Byte order for one word, written out from the link's byte-order rule
    task automatic add_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
`ifdef DEBUG_TX_MSB_FIRST_EN
            exp_q.push_back(w[31-8*k -: 8]);
`else
            exp_q.push_back(w[8*k +: 8]);
`endif
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("byte_wait_timeout", 32'(got_q.size() >= n), 32'd1);
        repeat (40) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_write_en_fifo = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_one(input logic [31:0] w);
        i_write_en_fifo = 1'b1;
        i_data_to_fifo  = w;
        @(negedge clk);
        i_write_en_fifo = 1'b0;
    endtask

    // uart_tx stand-in: record each started byte and answer with i_tx_done
    // 'delay' edges after the start pulse. It holds i_tx_done for two cycles
    // when resp_dbl is set.
    initial begin
        int cnt = 0;
        int pulse_left = 0;
        forever begin
            @(negedge clk);
            if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) i_tx_done = 1'b0;
            end
            if (o_tx_start === 1'b1) begin
                got_q.push_back(o_tx_data);
                cnt = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
            end
            if (cnt > 0 && resp_en) begin
                cnt--;
                if (cnt == 0) begin
                    i_tx_done  = 1'b1;
                    pulse_left = resp_dbl ? 2 : 1;
                end
            end
        end
    end

    always @(negedge clk) if (o_fifo_full === 1'b1) saw_full = 1'b1;

    initial begin
        int n, c;
        logic [31:0] w;

        @(negedge clk);
        do_reset();

        // Values straight after reset
        check_eq("rst_tx_start", o_tx_start, 0);
        check_eq("rst_tx_data", o_tx_data, 8'h00);
        check_eq("rst_empty", o_fifo_empty, 1);
        check_eq("rst_full", o_fifo_full, 0);
        check_eq("rst_overflow", o_overflow, 0);
        check_eq("rst_busy", o_busy, 0);

        // Single "endd" word, checking latency from push to first start
        resp_delay = 3;
        i_write_en_fifo = 1'b1;
        i_data_to_fifo  = 32'h656E6464;
        @(negedge clk);
        i_write_en_fifo = 1'b0;
        check_eq("t1_empty_after_push", o_fifo_empty, 0);
        check_eq("t1_start_n", o_tx_start, 0);
        @(negedge clk);
        check_eq("t1_start_n1", o_tx_start, 0);
        check_eq("t1_busy", o_busy, 1);
        @(negedge clk);
        check_eq("t1_start_n2", o_tx_start, 1);
        add_word(32'h656E6464);
        wait_bytes(4, 200);
        compare_stream("t1");
        check_eq("t1_busy_end", o_busy, 0);
        check_eq("t1_empty_end", o_fifo_empty, 1);

        // 32 back-to-back words, slow uart
        resp_delay = 10;
        saw_full = 1'b0;
        for (int i = 0; i < 32; i++) begin
            i_write_en_fifo = 1'b1;
            i_data_to_fifo  = 32'(i);
            add_word(32'(i));
            @(negedge clk);
        end
        i_write_en_fifo = 1'b0;
        wait_bytes(128, 3000);
        check_eq("t2_never_full", saw_full, 0);
        check_eq("t2_overflow", o_overflow, 0);
        compare_stream("t2");

        // Stalled uart: one word in flight plus DEPTH in the FIFO, rest dropped
        resp_en = 1'b0;
        for (int i = 0; i < 70; i++) begin
            i_write_en_fifo = 1'b1;
            i_data_to_fifo  = 32'(100 + i);
            if (i < DEPTH + 1) add_word(32'(100 + i));
            @(negedge clk);
        end
        i_write_en_fifo = 1'b0;
        check_eq("t3_full", o_fifo_full, 1);
        check_eq("t3_overflow", o_overflow, 1);
        check_eq("t3_one_start", got_q.size(), 1);
        resp_rand = 1'b1;
        resp_en   = 1'b1;
        wait_bytes(260, 6000);
        compare_stream("t3");
        check_eq("t3_busy_end", o_busy, 0);
        check_eq("t3_overflow_sticky", o_overflow, 1);

        // Reset after the second done of a word discards everything
        resp_rand  = 1'b0;
        resp_delay = 3;
        w = $urandom;
        push_one(w);
        push_one($urandom);
        n = 0;
        c = 0;
        while (n < 2 && c < 100) begin
            @(negedge clk);
            c++;
            if (o_tx_start === 1'b1) n++;
        end
        check_eq("t5_two_starts", n, 2);
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check_eq("t5_tx_start", o_tx_start, 0);
        check_eq("t5_empty", o_fifo_empty, 1);
        check_eq("t5_overflow", o_overflow, 0);
        check_eq("t5_busy", o_busy, 0);
        check_eq("t5_tx_data", o_tx_data, 8'h00);
        i_reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        push_one(32'hAABBCCDD);
        add_word(32'hAABBCCDD);
        wait_bytes(4, 200);
        compare_stream("t5");

        // Push and pop on the same edge with 10 words queued
        do_reset();
        resp_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            w = $urandom;
            i_write_en_fifo = 1'b1;
            i_data_to_fifo  = w;
            add_word(w);
            @(negedge clk);
        end
        i_write_en_fifo = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t4_first_start", got_q.size(), 1);
        n = 1;
        c = 0;
        resp_en = 1'b1;
        while (n < 4 && c < 200) begin
            @(negedge clk);
            c++;
            if (o_tx_start === 1'b1) n++;
        end
        check_eq("t4_four_starts", n, 4);
        // Last done lands 3 edges after the 4th start; the pop follows one edge later
        repeat (3) @(negedge clk);
        w = $urandom;
        add_word(w);
        push_one(w);
        resp_en = 1'b0;
        check_eq("t4_not_full", o_fifo_full, 0);
        for (int i = 0; i < DEPTH - 11; i++) begin
            w = $urandom;
            i_write_en_fifo = 1'b1;
            i_data_to_fifo  = w;
            add_word(w);
            @(negedge clk);
        end
        i_write_en_fifo = 1'b0;
        check_eq("t4_full_one_short", o_fifo_full, 0);
        w = $urandom;
        add_word(w);
        push_one(w);
        check_eq("t4_full_exact", o_fifo_full, 1);
        check_eq("t4_no_overflow", o_overflow, 0);
        resp_rand = 1'b1;
        resp_en   = 1'b1;
        wait_bytes(264, 6000);
        compare_stream("t4");

        // Spurious done pulses in IDLE and in SEND are ignored
        resp_rand  = 1'b0;
        resp_delay = 2;
        i_tx_done = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_tx_start === 1'b1) n++;
        end
        i_tx_done = 1'b0;
        check_eq("t6_idle_no_start", n, 0);
        check_eq("t6_idle_busy", o_busy, 0);
        resp_dbl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            add_word(w);
            push_one(w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_bytes(12, 400);
        compare_stream("t6");
        resp_dbl = 1'b0;

        // Randomised words, gaps, uart delays and done widths
        resp_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            resp_dbl = 1'($urandom_range(0, 1));
            for (int i = 0; i < 10; i++) begin
                w = $urandom;
                add_word(w);
                push_one(w);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_bytes(40, 1500);
            check_eq($sformatf("t7_overflow_r%0d", r), o_overflow, 0);
            compare_stream($sformatf("t7_r%0d", r));
            check_eq($sformatf("t7_idle_r%0d", r), o_busy, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
